product_accumulator: RTL
========================

Name: product_accumulator

Overview:
Multiply-accumulate back end for the filter datapath. It consumes the unsigned 8-bit products of the 4x4 multiplier stage one per handshake and sums a fixed-length frame of NumTerms products, one per filter tap. It presents the frame sum on a valid/ready output with saturation and an overflow flag. It sits directly downstream of the multiplier and upstream of the filter output register/consumer.

Parameters:
ProductWidth, 8, width of each unsigned input product.
AccWidth, 10, width of accumulator and sum_o. AccWidth >= ProductWidth + clog2(NumTerms) guarantees no saturation.
NumTerms, 4, products per frame. Must be >= 1.

Ports:
clk_i  input  1  clock; all logic is rising-edge.
rst_i  input  1  asynchronous, active-high reset.
clear_i  input  1  synchronous frame abort; highest priority after reset.
in_valid_i  input  1  product_i is valid.
in_ready_o  output  1  block accepts a product this cycle.
product_i  input  ProductWidth  unsigned product from the multiplier.
out_valid_o  output  1  sum_o and overflow_o are valid.
out_ready_i  input  1  consumer accepts the result.
sum_o  output  AccWidth  saturated frame sum.
overflow_o  output  1  frame sum saturated at least once.

Behaviour:
- Reset: one clock, async active-high reset. While rst_i is high: state=ACCUM, acc=0, count=0, sum_o=0, overflow_o=0, out_valid_o=0, in_ready_o=0. After rst_i deasserts, in_ready_o=1 from the first clock edge.
- All outputs are registered or decoded from state only. No combinational path from in_valid_i or out_ready_i to any output.
- State ACCUM: in_ready_o=1, out_valid_o=0.
  - Accept = in_valid_i & in_ready_o.
  - On accept: next = acc + product_i, computed at AccWidth+1 bits. If next > 2^AccWidth-1, clamp to all-ones and set the frame overflow flag.
  - If count < NumTerms-1: acc <= next, count++.
  - If count == NumTerms-1: sum_o <= next (clamped), overflow_o <= flag, acc <= 0, count <= 0, state <= HOLD.
- State HOLD: in_ready_o=0, out_valid_o=1. sum_o and overflow_o stay stable until the handshake.
  - out_valid_o & out_ready_i -> state <= ACCUM, out_valid_o <= 0.
- Latency: sum_o is valid on the cycle after the final product is accepted. Throughput is NumTerms+1 cycles per frame at minimum, with one bubble during the HOLD handshake.
- Saturation is sticky within a frame. Once clamped, further adds keep the value at all-ones. The overflow flag clears at frame start.
- clear_i=1 (synchronous): acc=0, count=0, overflow flag=0, state=ACCUM, out_valid_o=0. Any held result is discarded. A product presented in the same cycle is not accumulated, and in_ready_o is still 1 that cycle. clear_i in HOLD drops the result even if out_ready_i=1 in that cycle.
- NumTerms=1: every accepted product goes straight to HOLD.
- in_valid_i low in ACCUM: no state change. Gaps between products are allowed.
- Reset mid-frame or in HOLD: partial sum is lost, outputs return to reset values immediately (asynchronously).

Test Plan:
- Basic frame (defaults): products 10, 20, 30, 40 on consecutive cycles with out_ready_i=1 -> sum_o=100, overflow_o=0, out_valid_o high exactly 1 cycle after the 4th accept.
- Backpressure: frame 225 x4 with out_ready_i held low 5 cycles -> sum_o=900 stable and in_ready_o=0 throughout. Then out_ready_i=1 -> handshake, and in_ready_o=1 on the next cycle.
- Saturation (AccWidth=9): products 225, 225, 225, 1 -> sum_o=511, overflow_o=1. Next frame 1, 1, 1, 1 -> sum_o=4, overflow_o=0.
- Gapped input: products 5, idle 3 cycles, 6, idle, 7, 8 -> sum_o=26. Verify count advances only on accepts.
- clear_i: after 2 accepts (50, 60), assert clear_i together with in_valid_i=1 (99). Then send 1, 2, 3, 4 -> sum_o=10. Also assert clear_i in HOLD with out_ready_i=1 -> out_valid_o drops and no result is taken.
- Async reset: assert rst_i mid-frame between clock edges -> outputs reach reset values immediately without a clock edge. After release, a frame 1, 1, 1, 1 gives sum_o=4.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator
// Multiply-accumulate back end. It sums NumTerms unsigned products per frame,
// taking one product per valid/ready handshake. The frame sum is clamped to
// all-ones on overflow and presented on a valid/ready output port.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   clear_i      synchronous frame abort; drops the partial sum and any held result
//   in_valid_i   product_i is valid
//   in_ready_o   a product is accepted this cycle
//   product_i    unsigned product from the multiplier
//   out_valid_o  sum_o and overflow_o are valid
//   out_ready_i  the consumer takes the result
//   sum_o        saturated frame sum
//   overflow_o   the frame sum clamped at least once
//
// State table:
//   ST_ACCUM | taking products and summing the current frame
//   ST_HOLD  | frame result presented; waiting for the output handshake
module product_accumulator #(
    parameter int ProductWidth = 8,
    parameter int AccWidth     = 10,
    parameter int NumTerms     = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [ProductWidth-1:0] product_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [AccWidth-1:0]     sum_o,
    output logic                    overflow_o
);

    localparam int CountWidth = (NumTerms > 1) ? $clog2(NumTerms) : 1;
    localparam int SumWidth   = AccWidth + 1;
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(NumTerms - 1);

    typedef enum logic {
        ST_ACCUM,
        ST_HOLD
    } state_e;

    state_e                  state_q, state_d;
    logic [AccWidth-1:0]     acc_q, acc_d;
    logic [CountWidth-1:0]   count_q, count_d;
    logic                    ovf_flag_q, ovf_flag_d;
    logic [AccWidth-1:0]     sum_q, sum_d;
    logic                    overflow_q, overflow_d;
    // Holds in_ready_o low while reset is asserted, even though the state
    // register already reads ST_ACCUM. It goes high on the first clock edge.
    logic                    live_q, live_d;

    logic [SumWidth-1:0]     sum_ext;
    logic                    sat;
    logic [AccWidth-1:0]     next_acc;
    logic                    accept;

    assign in_ready_o  = live_q & (state_q == ST_ACCUM);
    assign out_valid_o = (state_q == ST_HOLD);
    assign sum_o       = sum_q;
    assign overflow_o  = overflow_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        ovf_flag_d = ovf_flag_q;
        sum_d      = sum_q;
        overflow_d = overflow_q;
        live_d     = 1'b1;

        // The extra carry bit detects overflow. A clamped accumulator stays at
        // all-ones on later adds, so saturation sticks for the rest of the frame.
        sum_ext  = SumWidth'(acc_q) + SumWidth'(product_i);
        sat      = sum_ext[AccWidth];
        next_acc = sat ? '1 : sum_ext[AccWidth-1:0];
        accept   = in_valid_i & in_ready_o;

        if (clear_i) begin
            acc_d      = '0;
            count_d    = '0;
            ovf_flag_d = 1'b0;
            state_d    = ST_ACCUM;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        if (count_q == LastCount) begin
                            sum_d      = next_acc;
                            overflow_d = ovf_flag_q | sat;
                            acc_d      = '0;
                            count_d    = '0;
                            ovf_flag_d = 1'b0;
                            state_d    = ST_HOLD;
                        end else begin
                            acc_d      = next_acc;
                            count_d    = count_q + 1'b1;
                            ovf_flag_d = ovf_flag_q | sat;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready_i) begin
                        state_d = ST_ACCUM;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_ACCUM;
            acc_q      <= '0;
            count_q    <= '0;
            ovf_flag_q <= 1'b0;
            sum_q      <= '0;
            overflow_q <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            ovf_flag_q <= ovf_flag_d;
            sum_q      <= sum_d;
            overflow_q <= overflow_d;
            live_q     <= live_d;
        end
    end

endmodule
